// File: rtl/fetch.sv
// Beta instruction fetch: owns the fetch PC, issues one-outstanding imem requests,
// buffers words in a 2-entry FIFO for decode and applies redirects with squash.
`ifndef INST_NOP
`define INST_NOP 32'h83FF_F800
`endif

module fetch #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [1:0]  redirect_sel,
  input  logic [31:0] br_addr,
  input  logic [31:0] j_addr,
  input  logic        redirect_sup,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_next,
  output logic [31:0] ir_next,
  output logic        fetch_bubble
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] ir;
  } entry_t;

  state_t      state;
  entry_t      fifo [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count, count_n;
  logic [31:0] fetch_pc, fetch_pc_n, target;
  logic        push, pop;
  entry_t      head;

  always_comb begin
    pop  = !stall && (count != 2'd0);
    push = (state == S_REQ) && imem_ack && !redirect;
    count_n = count;
    if (push && !pop)      count_n = count + 2'd1;
    else if (!push && pop) count_n = count - 2'd1;
    case (redirect_sel)
      2'd0:    target = {br_addr[31:2], 2'b00};
      2'd1:    target = {j_addr[31] & redirect_sup, j_addr[30:2], 2'b00};  // jump never gains supervisor
      2'd2:    target = {XADR_VEC[31:2], 2'b00};
      default: target = {RESET_VEC[31:2], 2'b00};
    endcase
    fetch_pc_n = fetch_pc;
    if (redirect)  fetch_pc_n = target;
    else if (push) fetch_pc_n = fetch_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_VEC;
      imem_addr <= RESET_VEC;
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
    end else begin
      fetch_pc <= fetch_pc_n;
      // address tracks the next fetch PC except while a request is pending
      if (!(imem_req && !imem_ack)) imem_addr <= fetch_pc_n;
      if (redirect) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        count <= count_n;
        if (push) begin
          fifo[wr_ptr] <= '{pc4: fetch_pc + 32'd4, ir: imem_rdata};
          wr_ptr       <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
      end
      case (state)
        S_IDLE:  if (!redirect && count_n < 2'd2) state <= S_REQ;
        S_REQ: begin
          if (imem_ack) state <= (!redirect && count_n < 2'd2) ? S_REQ : S_IDLE;
          else if (redirect) state <= S_DRAIN;
        end
        S_DRAIN: if (imem_ack) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_req     = (state == S_REQ) || (state == S_DRAIN);
  assign head         = fifo[rd_ptr];
  assign fetch_bubble = (count == 2'd0);
  assign ir_next      = fetch_bubble ? `INST_NOP : head.ir;
  assign pc_next      = fetch_bubble ? fetch_pc : head.pc4;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: transaction scoreboard of fetched words plus
// explicit checks at reset, redirects and FIFO saturation.
module tb_fetch;
  localparam logic [31:0] RV  = 32'h8000_0000;
  localparam logic [31:0] XV  = 32'h8000_0008;
  localparam logic [31:0] NOP = 32'h83FF_F800;
  localparam logic [31:0] K   = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst, stall, redirect, sup, ack;
  logic [1:0]  sel;
  logic [31:0] br, ja, rdata;
  logic        imem_req, fetch_bubble;
  logic [31:0] imem_addr, pc_next, ir_next;

  always #5 clk = ~clk;

  fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_sel(sel), .br_addr(br), .j_addr(ja), .redirect_sup(sup),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(ack),
    .imem_rdata(rdata), .pc_next(pc_next), .ir_next(ir_next),
    .fetch_bubble(fetch_bubble)
  );

  typedef struct { logic [31:0] pc4; logic [31:0] ir; } ent_t;
  ent_t        q[$];
  logic [31:0] exp_addr, drain_addr;
  logic        drain;
  int          evals = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    evals++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] tgt();
    case (sel)
      2'd0:    return {br[31:2], 2'b00};
      2'd1:    return {ja[31] & sup, ja[30:2], 2'b00};
      2'd2:    return XV;
      default: return RV;
    endcase
  endfunction

  // Called at a negedge: checks outputs, updates the model for the coming posedge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      rdata = imem_addr ^ K;
      if (!rst) begin
        q.delete();
        drain = 1'b0;
        exp_addr = RV;
      end else begin
        chk("bubble", {31'd0, fetch_bubble}, {31'd0, q.size() == 0});
        if (q.size() == 0) begin
          chk("ir_nop", ir_next, NOP);
          chk("pc_empty", pc_next, exp_addr);
        end else begin
          chk("ir_head", ir_next, q[0].ir);
          chk("pc_head", pc_next, q[0].pc4);
        end
        if (drain) chk("drain_addr_hold", imem_addr, drain_addr);
        if (!stall && q.size() > 0 && !redirect) void'(q.pop_front());
        if (imem_req && ack) begin
          if (!drain) begin
            chk("imem_addr", imem_addr, exp_addr);
            if (!redirect) begin
              q.push_back('{pc4: exp_addr + 32'd4, ir: rdata});
              exp_addr += 32'd4;
            end
          end else drain = 1'b0;
        end
        if (redirect) begin
          q.delete();
          exp_addr = tgt();
          if (imem_req && !ack && !drain) begin
            drain = 1'b1;
            drain_addr = imem_addr;
          end
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 0; stall = 0; redirect = 0; sel = 0; sup = 0; ack = 0;
    br = 0; ja = 0; rdata = 0; drain = 0; exp_addr = RV; drain_addr = 0;
    @(negedge clk);
    tick(2);
    rst = 1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_bubble", {31'd0, fetch_bubble}, 32'd1);
    chk("rst_ir", ir_next, NOP);
    chk("rst_pc", pc_next, RV);
    chk("rst_addr", imem_addr, RV);

    // streaming, ack tied high
    ack = 1;
    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RV);
    chk("first_bubble", {31'd0, fetch_bubble}, 32'd1);
    tick();
    chk("first_valid", {31'd0, fetch_bubble}, 32'd0);
    tick(8);

    // ack every third cycle
    for (int i = 0; i < 9; i++) begin
      ack = (i % 3 == 2);
      tick();
    end

    // stall with ack high: FIFO fills, requests stop
    stall = 1; ack = 1;
    tick(5);
    chk("sat_req", {31'd0, imem_req}, 32'd0);
    chk("sat_full", {30'd0, 2'(q.size())}, 32'd2);
    stall = 0;
    tick(6);

    // branch redirect with ack delayed
    ack = 0;
    tick(3);
    chk("outstanding", {31'd0, imem_req}, 32'd1);
    redirect = 1; sel = 2'd0; br = 32'h0000_1003;
    tick();
    redirect = 0;
    chk("br_flush", {31'd0, fetch_bubble}, 32'd1);
    tick();
    ack = 1;
    tick();
    tick();
    chk("br_addr", imem_addr, 32'h0000_1000);
    tick(4);

    // jumps: supervisor may be cleared but not set
    redirect = 1; sel = 2'd1; ja = 32'h8000_2000; sup = 0;
    tick();
    redirect = 0;
    tick();
    chk("j_user_req", {31'd0, imem_req}, 32'd1);
    chk("j_user", imem_addr, 32'h0000_2000);
    tick(3);
    redirect = 1; sup = 1;
    tick();
    redirect = 0;
    tick();
    chk("j_sup", imem_addr, 32'h8000_2000);
    tick(3);

    // exception redirect coincident with ack and stall
    redirect = 1; sel = 2'd2; stall = 1; ack = 1;
    tick();
    redirect = 0; stall = 0; ack = 0;
    tick();
    chk("x_bubble", {31'd0, fetch_bubble}, 32'd1);
    chk("x_req", {31'd0, imem_req}, 32'd1);
    chk("x_addr", imem_addr, XV);
    tick();

    // reset mid-request abandons it
    rst = 0;
    tick();
    rst = 1;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    ack = 1;
    tick();
    chk("restart_addr", imem_addr, RV);
    tick(6);

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
